fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Parametrised instruction-fetch stage. It replaces the loose PC register, PC controller and IF/ID pipe arrangement with a single block. The block owns the PC, drives a synchronous (1-cycle read latency) instruction ROM, and resolves EX-stage branches with a redirect/flush. It also supports stall from downstream hazard logic and delivers {instruction, pc, valid} to ID through an internal IF/ID register.

Parameters:
N, 32, instruction and PC width in bits
A, 12, ROM word-address width; rom_addr_o = low A bits of selected PC
PC_STEP, 1, sequential PC increment (1 = word addressing, 4 = byte addressing)
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
stall_i  in  1  hold PC, fetch tracking and IF/ID contents
branchselect_ex_i  in  2  branch mode of instruction in EX: 00 none, 01 always, 10 if Z, 11 if N
alu_flags_ex_i  in  2  EX flags: [0]=Z, [1]=N
pc_ex_i  in  N  PC of branch instruction in EX
offset_ex_i  in  N  sign-extended branch offset from EX
rom_addr_o  out  A  ROM read address
rom_data_i  in  N  ROM read data, valid one cycle after address
instruction_id_o  out  N  instruction to ID
pc_id_o  out  N  PC of instruction_id_o
valid_id_o  out  1  instruction_id_o is a real instruction (0 = bubble)
pc_select_o  out  1  redirect taken this cycle (combinational)
clear_pipes_o  out  1  flush request to ID/EX (combinational, equals pc_select_o)

Behaviour:
- Internal state: pc (N), pc_f (N, PC of in-flight ROM read), f_valid (1), IF/ID register {instruction_id, pc_id, valid_id}.
- Reset (RST=1 at edge): pc=RESET_PC, pc_f=0, f_valid=0, instruction_id_o=0, pc_id_o=0, valid_id_o=0. Reset wins over redirect and stall.
- taken = (mode 01) | (mode 10 & Z) | (mode 11 & N). pc_select_o = clear_pipes_o = taken; combinational, 0 while RST=1.
- target = pc_ex_i + offset_ex_i, modulo 2^N. Sequential next = pc + PC_STEP, modulo 2^N, wrapping to 0 at the top.
- rom_addr_o = stall_i ? pc_f[A-1:0] : pc[A-1:0]. While stalled the ROM re-reads the in-flight address, so rom_data_i stays matched to pc_f.
- Priority at each edge: RST > taken > stall_i > normal.
- taken: pc=target, f_valid=0, valid_id_o=0. instruction_id_o and pc_id_o hold. Stall is ignored. Target is issued on the following cycle.
- stall_i (not taken): pc, pc_f, f_valid and IF/ID all hold.
- normal: instruction_id_o=rom_data_i, pc_id_o=pc_f, valid_id_o=f_valid, pc_f=pc, f_valid=1, pc=next.
- Latency: an address issued at edge k appears on the IF/ID outputs after edge k+2. After reset release, the first valid_id_o=1 occurs 2 edges later, with pc_id_o=RESET_PC.
- Redirect penalty: 2 bubbles (valid_id_o=0) before the target instruction. Back-to-back taken branches re-target every cycle, and no valid output appears until two non-taken cycles elapse.
- Stall asserted mid-redirect: taken still applies. Stall asserted the cycle after a redirect holds the bubble.
- rom_data_i is sampled only on normal edges. Upper PC bits above A are ignored for addressing but carried in pc_id_o.

Test Plan:
- Reset then free-run, ROM[i]=i+100, N=32, PC_STEP=1: valid_id_o=0 for 2 edges, then pc_id_o=0,1,2,... with instruction_id_o=100,101,102..., one per cycle.
- branchselect_ex_i=01, pc_ex_i=5, offset_ex_i=12 for one cycle: pc_select_o=clear_pipes_o=1 that cycle; exactly 2 bubbles; next valid pc_id_o=17, instruction_id_o=117.
- Mode 10 with Z=0 -> no redirect, sequential stream continues. Mode 10 with Z=1 -> redirect. Mode 11 with N=1, offset=-3 (0xFFFFFFFD) at pc_ex_i=10 -> next valid pc_id_o=7.
- Assert stall_i 3 cycles while pc_id_o=4: IF/ID holds pc 4 / instr 104, rom_addr_o equals pc_f. After release, pc_id_o=5,6 with correct data and no skipped or duplicated PC.
- Stall and taken in the same cycle: redirect applies, bubbles inserted. Also RST asserted mid-stream while taken=1: all outputs zero next cycle and pc restarts at RESET_PC.
- PC_STEP=4, RESET_PC=0xFFFFFFF8: pc_id_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap), with rom_addr_o taking the low A bits.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction ROM,
// resolves EX-stage branches with redirect/flush and presents {instr, pc, valid} to ID.
module fetch_stage #(
    parameter int unsigned  N        = 32,
    parameter int unsigned  A        = 12,
    parameter logic [N-1:0] PC_STEP  = N'(1),
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         stall_i,
    input  logic [1:0]   branchselect_ex_i,
    input  logic [1:0]   alu_flags_ex_i,
    input  logic [N-1:0] pc_ex_i,
    input  logic [N-1:0] offset_ex_i,
    output logic [A-1:0] rom_addr_o,
    input  logic [N-1:0] rom_data_i,
    output logic [N-1:0] instruction_id_o,
    output logic [N-1:0] pc_id_o,
    output logic         valid_id_o,
    output logic         pc_select_o,
    output logic         clear_pipes_o
);

    localparam logic [1:0] BR_ALWAYS = 2'b01;
    localparam logic [1:0] BR_ZERO   = 2'b10;
    localparam logic [1:0] BR_NEG    = 2'b11;

    logic [N-1:0] pc;
    logic [N-1:0] pc_f;
    logic         f_valid;
    logic         taken;
    logic [N-1:0] target;
    logic [N-1:0] pc_seq;

    always_comb begin
        taken = 1'b0;
        case (branchselect_ex_i)
            BR_ALWAYS: taken = 1'b1;
            BR_ZERO:   taken = alu_flags_ex_i[0];
            BR_NEG:    taken = alu_flags_ex_i[1];
            default:   taken = 1'b0;
        endcase
        if (RST) taken = 1'b0;
    end

    assign target        = pc_ex_i + offset_ex_i;
    assign pc_seq        = pc + PC_STEP;
    // While stalled the ROM re-reads the in-flight address so its data stays paired with pc_f.
    assign rom_addr_o    = stall_i ? pc_f[A-1:0] : pc[A-1:0];
    assign pc_select_o   = taken;
    assign clear_pipes_o = taken;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc               <= RESET_PC;
            pc_f             <= '0;
            f_valid          <= 1'b0;
            instruction_id_o <= '0;
            pc_id_o          <= '0;
            valid_id_o       <= 1'b0;
        end else if (taken) begin
            // Kill both the in-flight fetch and the IF/ID entry; the target issues next cycle.
            pc         <= target;
            f_valid    <= 1'b0;
            valid_id_o <= 1'b0;
        end else if (!stall_i) begin
            instruction_id_o <= rom_data_i;
            pc_id_o          <= pc_f;
            valid_id_o       <= f_valid;
            pc_f             <= pc;
            f_valid          <= 1'b1;
            pc               <= pc_seq;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised + directed bench for fetch_stage: a queue-based fetch model predicts the
// IF/ID stream per edge, a negedge monitor pops and compares; a second instance covers wrap.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        stall_i = 1'b0;
    logic [1:0]  branchselect_ex_i = 2'b00;
    logic [1:0]  alu_flags_ex_i = 2'b00;
    logic [31:0] pc_ex_i = '0;
    logic [31:0] offset_ex_i = '0;
    logic [11:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] instruction_id_o;
    logic [31:0] pc_id_o;
    logic        valid_id_o;
    logic        pc_select_o;
    logic        clear_pipes_o;

    logic        rst2 = 1'b1;
    logic [11:0] rom_addr2;
    logic [31:0] rom_data2;
    logic [31:0] instr2;
    logic [31:0] pc_id2;
    logic        valid2;
    logic        pc_sel2;
    logic        clear2;

    int errors = 0;
    int checks = 0;
    bit wrap_done = 1'b0;

    // {exact, valid, pc, instr}; exact forces pc/instr comparison even when not valid
    logic [65:0] exp_q[$];

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .stall_i(stall_i),
        .branchselect_ex_i(branchselect_ex_i), .alu_flags_ex_i(alu_flags_ex_i),
        .pc_ex_i(pc_ex_i), .offset_ex_i(offset_ex_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .instruction_id_o(instruction_id_o), .pc_id_o(pc_id_o), .valid_id_o(valid_id_o),
        .pc_select_o(pc_select_o), .clear_pipes_o(clear_pipes_o)
    );

    fetch_stage #(.N(32), .A(12), .PC_STEP(32'd4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .CLK(CLK), .RST(rst2), .stall_i(1'b0),
        .branchselect_ex_i(2'b00), .alu_flags_ex_i(2'b00),
        .pc_ex_i(32'd0), .offset_ex_i(32'd0),
        .rom_addr_o(rom_addr2), .rom_data_i(rom_data2),
        .instruction_id_o(instr2), .pc_id_o(pc_id2), .valid_id_o(valid2),
        .pc_select_o(pc_sel2), .clear_pipes_o(clear2)
    );

    function automatic logic [31:0] rom_val(input logic [31:0] addr);
        return {20'd0, addr[11:0]} + 32'd100;
    endfunction

    // Synchronous ROMs, ROM[i] = i + 100
    always @(posedge CLK) begin
        rom_data_i <= rom_val({20'd0, rom_addr_o});
        rom_data2  <= rom_val({20'd0, rom_addr2});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_fq[$];       // fetches issued but not yet in IF/ID
    logic        m_init = 1'b0;
    logic        o_ex = 1'b0, o_v = 1'b0;
    logic [31:0] o_pc = '0, o_ins = '0;

    function automatic bit is_taken(input bit rst, input logic [1:0] m, input logic [1:0] f);
        if (rst) return 1'b0;
        return (m == 2'b01) || (m == 2'b10 && f[0]) || (m == 2'b11 && f[1]);
    endfunction

    task automatic model_edge(input bit rst, input bit st, input bit tk, input logic [31:0] tgt);
        if (rst) begin
            m_init = 1'b1;
            m_pc   = 32'd0;
            m_fq.delete();
            o_ex = 1'b1; o_v = 1'b0; o_pc = '0; o_ins = '0;
        end else if (tk) begin
            m_pc = tgt;
            m_fq.delete();
            o_v  = 1'b0;
        end else if (!st) begin
            if (m_fq.size() > 0) begin
                o_pc  = m_fq.pop_front();
                o_ins = rom_val(o_pc);
                o_v   = 1'b1;
            end else begin
                o_v = 1'b0;
            end
            o_ex = 1'b0;
            m_fq.push_back(m_pc);
            m_pc = m_pc + 32'd1;
        end
        if (m_init) exp_q.push_back({o_ex, o_v, o_pc, o_ins});
    endtask

    // ---------------- driver ----------------
    // Called at posedge+#1: applies inputs for this cycle, checks combinational outputs,
    // then advances across the next edge and records the model's prediction.
    task automatic drive(input bit rst, input bit st, input logic [1:0] m, input logic [1:0] f,
                         input logic [31:0] pe, input logic [31:0] off);
        bit tk;
        RST = rst; stall_i = st; branchselect_ex_i = m; alu_flags_ex_i = f;
        pc_ex_i = pe; offset_ex_i = off;
        tk = is_taken(rst, m, f);
        #1;
        chk("pc_select", {31'd0, pc_select_o}, {31'd0, tk});
        chk("clear_pipes", {31'd0, clear_pipes_o}, {31'd0, tk});
        if (m_init && !rst) begin
            if (!st) chk("rom_addr", {20'd0, rom_addr_o}, {20'd0, m_pc[11:0]});
            else if (m_fq.size() > 0) chk("rom_addr_stall", {20'd0, rom_addr_o}, {20'd0, m_fq[0][11:0]});
        end
        @(posedge CLK);
        #1;
        model_edge(rst, st, tk, pe + off);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [65:0] e;
            e = exp_q.pop_front();
            chk("valid_id", {31'd0, valid_id_o}, {31'd0, e[64]});
            if (e[64] || e[65]) begin
                chk("pc_id", pc_id_o, e[63:32]);
                chk("instruction_id", instruction_id_o, e[31:0]);
            end
        end
    end

    // ---------------- main stimulus ----------------
    initial begin
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        drive(1'b1, 1'b0, 2'b01, 2'b00, 3, 4);          // reset beats taken
        run(8);
        drive(1'b0, 1'b0, 2'b01, 2'b00, 32'd5, 32'd12); // always -> 17
        run(5);
        drive(1'b0, 1'b0, 2'b10, 2'b00, 32'd40, 32'd9); // Z=0: no redirect
        run(3);
        drive(1'b0, 1'b0, 2'b10, 2'b01, 32'd20, 32'd3); // Z=1 -> 23
        run(4);
        drive(1'b0, 1'b0, 2'b11, 2'b10, 32'd10, 32'hFFFF_FFFD); // N=1 -> 7
        run(4);
        // stall 3 cycles while pc_id=4
        drive(1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
        run(6);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'b00, 2'b00, 0, 0);
        run(4);
        // stall and taken together, then stall just after redirect
        drive(1'b0, 1'b1, 2'b01, 2'b00, 32'd100, 32'd50);
        drive(1'b0, 1'b1, 2'b00, 2'b00, 0, 0);
        run(4);
        // back-to-back redirects
        drive(1'b0, 1'b0, 2'b01, 2'b00, 32'd300, 32'd1);
        drive(1'b0, 1'b0, 2'b01, 2'b00, 32'd400, 32'd2);
        drive(1'b0, 1'b0, 2'b11, 2'b10, 32'd500, 32'd3);
        run(4);
        // reset while taken
        drive(1'b1, 1'b0, 2'b01, 2'b00, 32'd77, 32'd1);
        run(4);
        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit r, s;
            logic [1:0] m;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 4) == 0);
            m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(r, s, m, 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        run(3);
        @(negedge CLK); @(negedge CLK);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("wrap_seq_done", {31'd0, wrap_done}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- PC_STEP=4 wrap instance ----------------
    initial begin
        rst2 = 1'b1;
        repeat (2) @(posedge CLK);
        #1 rst2 = 1'b0;
        chk("wrap_valid_r", {31'd0, valid2}, 32'd0);
        chk("wrap_pc_r", pc_id2, 32'd0);
        chk("wrap_addr0", {20'd0, rom_addr2}, 32'hFF8);
        @(posedge CLK); #1;
        chk("wrap_valid_e1", {31'd0, valid2}, 32'd0);
        chk("wrap_addr1", {20'd0, rom_addr2}, 32'hFFC);
        @(posedge CLK); #1;
        chk("wrap_valid_e2", {31'd0, valid2}, 32'd1);
        chk("wrap_pc_e2", pc_id2, 32'hFFFF_FFF8);
        chk("wrap_ins_e2", instr2, 32'hFF8 + 32'd100);
        chk("wrap_addr2", {20'd0, rom_addr2}, 32'h000);
        @(posedge CLK); #1;
        chk("wrap_pc_e3", pc_id2, 32'hFFFF_FFFC);
        chk("wrap_ins_e3", instr2, 32'hFFC + 32'd100);
        @(posedge CLK); #1;
        chk("wrap_pc_e4", pc_id2, 32'h0000_0000);
        chk("wrap_ins_e4", instr2, 32'd100);
        chk("wrap_sel", {31'd0, pc_sel2 | clear2}, 32'd0);
        wrap_done = 1'b1;
    end

endmodule
